// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for a dual-issue pipeline.
// Register 0 always reads as zero. Same-cycle writes can be forwarded to the
// read ports, and a per-register busy scoreboard tracks registers whose
// producer has issued but not yet written back.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int NREAD      = 4,
  parameter int NWRITE     = 2,
  parameter int BYPASS     = 1,
  localparam int ADDR_W    = $clog2(REG_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREAD-1:0]             rd_en,
  input  logic [NREAD*ADDR_W-1:0]      rd_addr,
  output logic [NREAD*DATA_WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]             rd_busy,
  input  logic [NWRITE-1:0]            wr_en,
  input  logic [NWRITE*ADDR_W-1:0]     wr_addr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_W-1:0]            iss_addr,
  input  logic                         flush
);

  // Architectural state
  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];
  logic [REG_NUM-1:0]    r_busy;

  // Next-state values
  logic [DATA_WIDTH-1:0] w_regs_next [REG_NUM];
  logic [REG_NUM-1:0]    w_busy_next;
  logic [REG_NUM-1:0]    w_clr;
  logic [REG_NUM-1:0]    w_set;
  logic [ADDR_W-1:0]     w_waddr;
  logic                  w_wen;

  // Read-path temporaries
  logic [ADDR_W-1:0]     w_raddr;
  logic                  w_hit;
  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_fwd;

  // Register update: ports are applied in ascending order so the highest-index
  // port wins an address conflict; writes to r0 are dropped.
  always_comb begin
    w_regs_next = r_regs;
    w_clr       = '0;
    w_waddr     = '0;
    w_wen       = 1'b0;
    for (int p = 0; p < NWRITE; p++) begin
      w_waddr = wr_addr[p*ADDR_W +: ADDR_W];
      w_wen   = wr_en[p] && (w_waddr != '0);
      w_regs_next[w_waddr] = w_wen ? wr_data[p*DATA_WIDTH +: DATA_WIDTH]
                                   : w_regs_next[w_waddr];
      w_clr[w_waddr]       = w_clr[w_waddr] | w_wen;
    end
    w_regs_next[0] = '0;
  end

  // Scoreboard update: a new issue outranks a writeback to the same register,
  // and flush squashes everything including a same-cycle issue.
  always_comb begin
    w_set = '0;
    w_set[iss_addr] = iss_en && (iss_addr != '0);
    w_busy_next = flush ? '0 : ((r_busy & ~w_clr) | w_set);
    w_busy_next[0] = 1'b0;
  end

  // State registers with asynchronous clear; r0 and busy[0] only ever load 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < REG_NUM; k++) begin
        r_regs[k] <= '0;
      end
      r_busy <= '0;
    end else begin
      r_regs <= w_regs_next;
      r_busy <= w_busy_next;
    end
  end

  // Combinational read ports: forwarded write data when enabled and matching,
  // otherwise stored data and busy bit. Everything reads zero while in reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_raddr = '0;
    w_hit   = 1'b0;
    w_match = 1'b0;
    w_fwd   = '0;
    for (int i = 0; i < NREAD; i++) begin
      w_raddr = rd_addr[i*ADDR_W +: ADDR_W];
      w_hit   = 1'b0;
      w_fwd   = '0;
      for (int p = 0; p < NWRITE; p++) begin
        w_match = (BYPASS != 0) && wr_en[p] &&
                  (wr_addr[p*ADDR_W +: ADDR_W] == w_raddr);
        w_hit   = w_hit | w_match;
        w_fwd   = w_match ? wr_data[p*DATA_WIDTH +: DATA_WIDTH] : w_fwd;
      end
      if (rst && rd_en[i] && (w_raddr != '0)) begin
        if (w_hit) begin
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_fwd;
          rd_busy[i] = 1'b0;
        end else begin
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_raddr];
          rd_busy[i] = r_busy[w_raddr];
        end
      end else begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

endmodule
